// File: rtl/midi_note_decoder.sv
// midi_note_decoder: MIDI channel-message parser producing note on/off events
// Ports: clock_50_000_000/reset (sync, active-high); rx_byte/rx_valid byte stream in;
//   note_status/note_number/note_velocity held event fields, note_ready 1-cycle strobe;
//   stray_data 1-cycle strobe for data bytes with no running status.
// Optional: define MIDI_CC_DECODE_EN to add cc_number/cc_value/cc_ready (Control Change 0xBn).
module midi_note_decoder #(
  parameter int CHANNEL = 0,
  parameter int OMNI = 0,
  parameter int DATA_WIDTH = 7
) (
  input  logic                  clock_50_000_000,
  input  logic                  reset,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic                  note_status,
  output logic [DATA_WIDTH-1:0] note_number,
  output logic [DATA_WIDTH-1:0] note_velocity,
  output logic                  note_ready,
`ifdef MIDI_CC_DECODE_EN
  output logic [DATA_WIDTH-1:0] cc_number,
  output logic [DATA_WIDTH-1:0] cc_value,
  output logic                  cc_ready,
`endif
  output logic                  stray_data
);
  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SKIP} state_t;
  localparam logic [3:0] ch_sel = 4'(CHANNEL);
  state_t state, state_n;
  logic [3:0] run_hi, run_hi_n;
  logic [6:0] d1, d1_n;
  logic status_n, ready_n, stray_n;
  logic [DATA_WIDTH-1:0] number_n, velocity_n;
  logic is_rt, is_sys, ch_ok, is_note, is_cc, accept, vel_nz;
`ifdef MIDI_CC_DECODE_EN
  logic [DATA_WIDTH-1:0] cc_number_n, cc_value_n;
  logic cc_ready_n;
`endif
  assign is_rt   = rx_byte[7:3] == 5'b11111;
  assign is_sys  = rx_byte[7:4] == 4'hF;
  assign ch_ok   = (OMNI != 0) || (rx_byte[3:0] == ch_sel);
  assign is_note = rx_byte[7:4] == 4'h8 || rx_byte[7:4] == 4'h9;
`ifdef MIDI_CC_DECODE_EN
  assign is_cc   = rx_byte[7:4] == 4'hB;
`else
  assign is_cc   = 1'b0;
`endif
  assign accept  = ch_ok && (is_note || is_cc);
  assign vel_nz  = rx_byte[6:0] != 7'd0;
  always_comb begin
    state_n    = state;
    run_hi_n   = run_hi;
    d1_n       = d1;
    status_n   = note_status;
    number_n   = note_number;
    velocity_n = note_velocity;
    ready_n    = 1'b0;
    stray_n    = 1'b0;
`ifdef MIDI_CC_DECODE_EN
    cc_number_n = cc_number;
    cc_value_n  = cc_value;
    cc_ready_n  = 1'b0;
`endif
    if (rx_valid && !is_rt) begin
      if (rx_byte[7]) begin
        run_hi_n = is_sys ? 4'h0 : rx_byte[7:4];
        // EOX carries no data, so following data bytes have no running status
        state_n  = (rx_byte == 8'hF7) ? IDLE : (!is_sys && accept) ? WAIT_D1 : SKIP;
      end else begin
        case (state)
          IDLE: stray_n = 1'b1;
          WAIT_D1: begin
            d1_n    = rx_byte[6:0];
            state_n = WAIT_D2;
          end
          WAIT_D2: begin
            state_n = WAIT_D1;
`ifdef MIDI_CC_DECODE_EN
            if (run_hi == 4'hB) begin
              cc_number_n = DATA_WIDTH'(d1);
              cc_value_n  = DATA_WIDTH'(rx_byte[6:0]);
              cc_ready_n  = 1'b1;
            end else begin
`else
            begin
`endif
              // Note On with zero velocity is an Off by MIDI convention
              status_n   = run_hi == 4'h9 && vel_nz;
              number_n   = DATA_WIDTH'(d1);
              velocity_n = (run_hi == 4'h9 && vel_nz) ? DATA_WIDTH'(rx_byte[6:0]) : '0;
              ready_n    = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      state         <= IDLE;
      run_hi        <= 4'h0;
      d1            <= 7'd0;
      note_status   <= 1'b0;
      note_number   <= '0;
      note_velocity <= '0;
      note_ready    <= 1'b0;
      stray_data    <= 1'b0;
    end else begin
      state         <= state_n;
      run_hi        <= run_hi_n;
      d1            <= d1_n;
      note_status   <= status_n;
      note_number   <= number_n;
      note_velocity <= velocity_n;
      note_ready    <= ready_n;
      stray_data    <= stray_n;
    end
  end
`ifdef MIDI_CC_DECODE_EN
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      cc_number <= '0;
      cc_value  <= '0;
      cc_ready  <= 1'b0;
    end else begin
      cc_number <= cc_number_n;
      cc_value  <= cc_value_n;
      cc_ready  <= cc_ready_n;
    end
  end
`endif
endmodule

// File: tb/tb_midi_note_decoder.sv
// tb_midi_note_decoder: vector table, hand sequences and randomized model check of midi_note_decoder
module tb_midi_note_decoder;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       note_status, note_ready, stray_data;
  logic [6:0] note_number, note_velocity;
`ifdef MIDI_CC_DECODE_EN
  logic [6:0] cc_number, cc_value;
  logic       cc_ready;
`endif
  int tests = 0;
  int failed = 0;
  midi_note_decoder #(.CHANNEL(0), .OMNI(0), .DATA_WIDTH(7)) dut (
    .clock_50_000_000(clk),
    .reset(reset),
    .rx_byte(rx_byte),
    .rx_valid(rx_valid),
    .note_status(note_status),
    .note_number(note_number),
    .note_velocity(note_velocity),
    .note_ready(note_ready),
`ifdef MIDI_CC_DECODE_EN
    .cc_number(cc_number),
    .cc_value(cc_value),
    .cc_ready(cc_ready),
`endif
    .stray_data(stray_data)
  );
  always #10 clk = ~clk;
  typedef struct {
    logic [7:0] b;
    logic       rdy;
    logic       stray;
    logic       st;
    logic [6:0] num;
    logic [6:0] vel;
  } vec_t;
  vec_t vecs[$];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic send(input vec_t v, input string tag);
    rx_byte = v.b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    chk({tag, " ready"}, 32'(note_ready), 32'(v.rdy));
    chk({tag, " stray"}, 32'(stray_data), 32'(v.stray));
    if (v.rdy) begin
      chk({tag, " status"}, 32'(note_status), 32'(v.st));
      chk({tag, " number"}, 32'(note_number), 32'(v.num));
      chk({tag, " velocity"}, 32'(note_velocity), 32'(v.vel));
    end
  endtask
  function automatic vec_t mk(input logic [7:0] b, input logic rdy = 0, input logic stray = 0,
                              input logic st = 0, input logic [6:0] num = 0, input logic [6:0] vel = 0);
    vec_t v;
    v.b = b; v.rdy = rdy; v.stray = stray; v.st = st; v.num = num; v.vel = vel;
    return v;
  endfunction
  function automatic logic [7:0] pick();
    int k = $urandom_range(0, 99);
    if (k < 50) return {1'b0, 7'($urandom)};
    if (k < 70) return 8'h80 | 8'($urandom_range(0, 1) << 4) | 8'($urandom_range(0, 1));
    if (k < 80) return 8'($urandom_range(8'hA0, 8'hEF));
    if (k < 88) return 8'($urandom_range(8'hF0, 8'hF7));
    return 8'($urandom_range(8'hF8, 8'hFF));
  endfunction
  // reference model state: message-level view of the stream
  bit         m_idle, m_acc;
  logic [7:0] m_rs;
  logic [6:0] m_q[$];
  logic       e_rdy, e_stray, e_st;
  logic [6:0] e_num, e_vel;
  initial begin
    vecs.push_back(mk(8'h90));
    vecs.push_back(mk(8'h3C));
    vecs.push_back(mk(8'h64, 1, 0, 1, 7'd60, 7'd100));
    vecs.push_back(mk(8'h40));
    vecs.push_back(mk(8'h00, 1, 0, 0, 7'd64, 7'd0));
    vecs.push_back(mk(8'h90));
    vecs.push_back(mk(8'hF8));
    vecs.push_back(mk(8'h3C));
    vecs.push_back(mk(8'hFE));
    vecs.push_back(mk(8'h50, 1, 0, 1, 7'd60, 7'd80));
    vecs.push_back(mk(8'h91));
    vecs.push_back(mk(8'h3C));
    vecs.push_back(mk(8'h64));
    vecs.push_back(mk(8'h80));
    vecs.push_back(mk(8'h3C));
    vecs.push_back(mk(8'h40, 1, 0, 0, 7'd60, 7'd0));
    vecs.push_back(mk(8'hF0));
    vecs.push_back(mk(8'h7E));
    vecs.push_back(mk(8'h10));
    vecs.push_back(mk(8'hF7));
    vecs.push_back(mk(8'h3C, 0, 1));
    vecs.push_back(mk(8'h90));
    vecs.push_back(mk(8'h3C));
    vecs.push_back(mk(8'h90));
    vecs.push_back(mk(8'h45));
    vecs.push_back(mk(8'h7F, 1, 0, 1, 7'd69, 7'd127));
    vecs.push_back(mk(8'hB0));
    vecs.push_back(mk(8'h10));
    vecs.push_back(mk(8'h20));
    vecs.push_back(mk(8'h3C));
    vecs.push_back(mk(8'h90));
    vecs.push_back(mk(8'h3C));
    vecs.push_back(mk(8'h00, 1, 0, 0, 7'd60, 7'd0));
    vecs.push_back(mk(8'hA0));
    vecs.push_back(mk(8'h3C));
    vecs.push_back(mk(8'h9F));
    vecs.push_back(mk(8'h3C));
    vecs.push_back(mk(8'h40));
    repeat (2) @(negedge clk);
    chk("reset ready", 32'(note_ready), 0);
    chk("reset stray", 32'(stray_data), 0);
    chk("reset status", 32'(note_status), 0);
    chk("reset number", 32'(note_number), 0);
    chk("reset velocity", 32'(note_velocity), 0);
    reset = 1'b0;
    foreach (vecs[i]) send(vecs[i], $sformatf("vec%0d", i));
    // idle gaps with garbage on rx_byte mid-message
    send(mk(8'h90), "gap status");
    send(mk(8'h3C), "gap d1");
    rx_byte = 8'h90;
    repeat (3) begin
      @(negedge clk);
      chk("gap idle ready", 32'(note_ready), 0);
    end
    send(mk(8'h55, 1, 0, 1, 7'd60, 7'd85), "gap d2");
    // reset mid-message discards partial message and running status
    send(mk(8'h90), "rst status");
    send(mk(8'h3C), "rst d1");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    send(mk(8'h64, 0, 1), "rst d2");
    chk("rst status", 32'(note_status), 0);
    chk("rst number", 32'(note_number), 0);
    chk("rst velocity", 32'(note_velocity), 0);
    // randomized stream against the message-level model
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_idle = 1; m_acc = 0; m_rs = 0; m_q.delete();
    e_st = 0; e_num = 0; e_vel = 0;
    for (int c = 0; c < 3000; c++) begin
      logic [7:0] b;
      logic v, r;
      r = $urandom_range(0, 199) == 0;
      v = $urandom_range(0, 3) != 0;
      b = pick();
      reset = r; rx_valid = v; rx_byte = b;
      e_rdy = 0; e_stray = 0;
      if (r) begin
        m_idle = 1; m_acc = 0; m_rs = 0; m_q.delete();
        e_st = 0; e_num = 0; e_vel = 0;
      end else if (v && b < 8'hF8) begin
        if (b[7]) begin
          m_q.delete();
          m_rs = b;
          m_idle = b == 8'hF7;
          m_acc = b < 8'hF0 && (b[7:4] == 4'h8 || b[7:4] == 4'h9) && b[3:0] == 4'h0;
        end else if (m_idle) e_stray = 1;
        else if (m_acc) begin
          m_q.push_back(b[6:0]);
          if (m_q.size() == 2) begin
            e_rdy = 1;
            e_st = m_rs[7:4] == 4'h9 && m_q[1] != 0;
            e_num = m_q[0];
            e_vel = e_st ? m_q[1] : 7'd0;
            m_q.delete();
          end
        end
      end
      @(negedge clk);
      chk("rnd ready", 32'(note_ready), 32'(e_rdy));
      chk("rnd stray", 32'(stray_data), 32'(e_stray));
      chk("rnd status", 32'(note_status), 32'(e_st));
      chk("rnd number", 32'(note_number), 32'(e_num));
      chk("rnd velocity", 32'(note_velocity), 32'(e_vel));
    end
    reset = 1'b0;
    rx_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
